// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte sequencer: START, address+R/W, one data byte, STOP.
// Quarter-bit tick derived from sys_clk; all state on one clock.
module i2c_master_byte_ctrl #(
  parameter int unsigned QDIV = 500,
  parameter int unsigned CW   = 11
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] AACK  = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] DACK  = 3'd5;
  localparam logic [2:0] STOP  = 3'd6;

  logic [2:0]    state, n_state;
  logic [1:0]    phase, n_phase;
  logic [2:0]    bit_cnt, n_bit;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg, dreg;
  logic          rw_q, samp;
  logic          tick, n_scl, n_sda, mid;

  assign tick = busy && (cnt == CW'(QDIV - 1));

  // Next bit position within the transaction, advanced once per tick.
  always_comb begin
    n_state = state;
    n_phase = phase + 2'd1;
    n_bit   = bit_cnt;
    if (phase == 2'd3) begin
      case (state)
        START: begin
          n_state = ADDR;
          n_bit   = 3'd7;
        end
        ADDR: begin
          if (bit_cnt == 3'd0) n_state = AACK;
          else n_bit = bit_cnt - 3'd1;
        end
        AACK: begin
          if (samp) n_state = STOP;
          else begin
            n_state = DATA;
            n_bit   = 3'd7;
          end
        end
        DATA: begin
          if (bit_cnt == 3'd0) n_state = DACK;
          else n_bit = bit_cnt - 3'd1;
        end
        DACK:    n_state = STOP;
        STOP:    n_state = IDLE;
        default: n_state = IDLE;
      endcase
    end
  end

  // Pad drive levels for the phase about to begin.
  always_comb begin
    mid   = (n_phase == 2'd1) || (n_phase == 2'd2);
    n_scl = 1'b0;
    n_sda = 1'b0;
    case (n_state)
      START: begin
        n_scl = (n_phase == 2'd3);
        n_sda = n_phase[1];
      end
      ADDR: begin
        n_scl = !mid;
        n_sda = !shreg[n_bit];
      end
      AACK: n_scl = !mid;
      DATA: begin
        n_scl = !mid;
        n_sda = !rw_q && !dreg[n_bit];
      end
      DACK: n_scl = !mid;
      STOP: begin
        n_scl = (n_phase == 2'd0);
        n_sda = (n_phase != 2'd3);
      end
      default: begin
        n_scl = 1'b0;
        n_sda = 1'b0;
      end
    endcase
  end

  // Request capture, tick counting, sampling and result reporting.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= 2'd0;
      bit_cnt <= 3'd0;
      cnt     <= '0;
      shreg   <= 8'd0;
      dreg    <= 8'd0;
      rw_q    <= 1'b0;
      samp    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= 8'd0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && !done) begin
          shreg   <= {addr, rw};
          dreg    <= wdata;
          rw_q    <= rw;
          ack_err <= 1'b0;
          busy    <= 1'b1;
          cnt     <= '0;
          phase   <= 2'd0;
          bit_cnt <= 3'd7;
          state   <= START;
        end
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          state   <= n_state;
          phase   <= n_phase;
          bit_cnt <= n_bit;
          scl_oe  <= n_scl;
          sda_oe  <= n_sda;
          if (phase == 2'd1) begin
            samp <= sda_i;
            if (state == DATA && rw_q) dreg <= {dreg[6:0], sda_i};
          end
          if (phase == 2'd3) begin
            if (state == AACK && samp) ack_err <= 1'b1;
            if (state == DACK && !rw_q && samp) ack_err <= 1'b1;
            if (state == STOP) begin
              busy <= 1'b0;
              done <= 1'b1;
              if (rw_q && !ack_err) rdata <= dreg;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
Single-transaction I2C master sequencer: on a start pulse it issues START, the 7-bit address plus R/W bit, one data byte (write or read) and STOP, with ACK handling. It replaces free-running derived SCL/SDA clocks with a sys_clk-domain quarter-bit tick, so all logic runs on one clock. It sits between a register/CPU front end and the open-drain SCL/SDA pad drivers.

Parameters:
QDIV, 500, sys_clk cycles per quarter SCL period (SCL period = 4*QDIV cycles); legal range 2..2047
CW, 11, width of quarter-tick counter; must hold QDIV-1

Ports:
sys_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle request; accepted only when busy=0
rw  in  1  0=write byte, 1=read byte
addr  in  7  target address
wdata  in  8  byte to write
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at transaction end
ack_err  out  1  1 if the last transaction saw a NACK; valid with done
rdata  out  8  byte read; valid with done when rw=1 and ack_err=0
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  sampled SDA pad level

Behaviour:
- Reset (reset=0 at a sys_clk edge): state IDLE, busy=0, done=0, ack_err=0, rdata=0, scl_oe=0, sda_oe=0, tick counter=0. Reset mid-transaction aborts immediately, lines released next edge, no STOP generated.
- Accept: in IDLE with start=1, latch {addr,rw} into shift reg and wdata into data reg, clear ack_err, busy=1 next cycle. start while busy=1 ignored, latched values unchanged.
- Tick: counter counts 0..QDIV-1 while busy; tick when counter=QDIV-1; each tick advances phase p (0..3). Phase 3 tick advances bit/state.
- Data bit phases: p0 SCL low, SDA set to bit (MSB first); p1,p2 SCL released; p3 SCL low. SDA sampled into sda_i capture on tick ending p1.
- States (each one bit time = 4 phases):
  IDLE: both released.
  START: p0,p1 both released; p2 SDA low, SCL released; p3 SDA low, SCL low.
  ADDR: 8 bits, {addr,rw}.
  AACK: SDA released; sampled 0 -> DATA; 1 -> ack_err=1, go STOP.
  DATA: 8 bits; write drives wdata MSB first; read releases SDA and shifts sampled bits into rdata MSB first.
  DACK: write: SDA released, sampled 1 sets ack_err. Read: master releases SDA (NACK, single-byte read). Then STOP.
  STOP: p0 SDA low, SCL low; p1,p2 SDA low, SCL released; p3 both released.
- After STOP p3 tick: state IDLE, busy=0, done=1 for exactly one cycle. start in that same cycle is not accepted (accepted from next cycle).
- Duration from accept to done: full transaction 20 bit times = 80*QDIV cycles (+1 accept cycle); address NACK 11 bit times = 44*QDIV cycles (+1).
- rdata holds until next read completes; on write or NACK rdata unchanged.
- Outputs registered; scl_oe/sda_oe change only on tick boundaries.
- No clock stretching, no arbitration detection (single-master bus).

Test Plan:
- QDIV=4, write addr=0x50 data=0xA5, slave model ACKs both -> bus decodes START, 0xA0, ACK, 0xA5, ACK, STOP; done at cycle 321 after accept, ack_err=0.
- QDIV=4, write addr=0x22, slave NACKs address -> no data byte on bus, STOP follows AACK, done at cycle 177, ack_err=1.
- QDIV=4, read addr=0x48, slave ACKs and returns 0x3C -> address byte 0x91 seen, master NACKs data, rdata=0x3C with done, ack_err=0.
- Write with data NACK -> full 20-bit sequence, ack_err=1, rdata unchanged.
- start pulsed mid-transaction with different addr/wdata -> ignored, bus traffic and result match first request; start on the done cycle ignored, start one cycle later accepted.
- reset=0 during DATA bit 3 -> next edge scl_oe=0, sda_oe=0, busy=0, ack_err=0, rdata=0; a fresh start afterwards completes normally.
